// File: rtl/serdes_model_pkg.sv
// rtl/serdes_model_pkg.sv - shared constants, FSM encoding and lane-index helpers for the SERDES link model
package serdes_model_pkg;

  // K28.5 comma byte used for training fill
  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_UP    = 2'd2
  } link_state_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a lane index, at least one bit so a single-lane link still has a rot port
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_delay_line.sv
// rtl/serdes_delay_line.sv - WIDTH x DEPTH shift register with synchronous reset
module serdes_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every stage one place per clock; reset clears the whole line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/serdes_link_model.sv
// rtl/serdes_link_model.sv - byte-lane SERDES link model: rotation, lock training, latency, burst errors
module serdes_link_model
  import serdes_model_pkg::*;
#(
  parameter int         NBYTES      = 2,
  parameter int         LATENCY     = 1,
  parameter int         LOCK_CYCLES = 8,
  parameter logic [7:0] COMMA       = K28_5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBYTES-1:0]             tx_k,
  input  logic [8*NBYTES-1:0]           tx_dat,
  input  logic [lane_idx_w(NBYTES)-1:0] rot,
  input  logic                          link_up,
  input  logic                          err_trig,
  input  logic [7:0]                    err_len,
  input  logic [8*NBYTES-1:0]           err_mask,
  output logic [NBYTES-1:0]             rx_k,
  output logic [8*NBYTES-1:0]           rx_dat,
  output logic                          rx_lock,
  output logic                          err_busy,
  output logic [15:0]                   err_words
);

  localparam int DW = 8 * NBYTES;
  localparam int PW = 9 * NBYTES;
  localparam int CW = clog2(LOCK_CYCLES + 1);

  logic [DW-1:0]     held_dat_q;
  logic [NBYTES-1:0] held_k_q;
  logic [2*DW-1:0]   win_dat;
  logic [2*NBYTES-1:0] win_k;
  logic [DW-1:0]     rot_dat;
  logic [NBYTES-1:0] rot_k;

  link_state_e       state_q, state_d;
  logic [CW-1:0]     train_cnt_q, train_cnt_d;
  logic [PW-1:0]     pipe_in;
  logic [PW-1:0]     pipe_out;
  logic              link_is_up;

  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [15:0]       err_words_q, err_words_d;

  // Previous word, needed to build the misaligned window
  always_ff @(posedge clk) begin
    if (rst) begin
      held_dat_q <= '0;
      held_k_q   <= '0;
    end else begin
      held_dat_q <= tx_dat;
      held_k_q   <= tx_k;
    end
  end

  // Pick NBYTES consecutive lanes out of {current, held}; rot=0 selects the current word
  always_comb begin
    int r;
    r       = int'(rot) % NBYTES;
    win_dat = {tx_dat, held_dat_q};
    win_k   = {tx_k, held_k_q};
    rot_dat = '0;
    rot_k   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rot_dat[8*i +: 8] = win_dat[8*(NBYTES - r + i) +: 8];
      rot_k[i]          = win_k[NBYTES - r + i];
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DOWN;
    end else begin
      state_q <= state_d;
    end
  end

  // Training cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      train_cnt_q <= '0;
    end else begin
      train_cnt_q <= train_cnt_d;
    end
  end

  // Lock FSM next state: TRAIN lasts exactly LOCK_CYCLES cycles while link_up holds
  always_comb begin
    state_d     = state_q;
    train_cnt_d = '0;
    case (state_q)
      ST_DOWN: begin
        if (link_up) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!link_up) begin
          state_d = ST_DOWN;
        end else if (train_cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d = ST_UP;
        end else begin
          train_cnt_d = train_cnt_q + CW'(1);
        end
      end
      ST_UP: begin
        if (!link_up) state_d = ST_DOWN;
      end
      default: state_d = ST_DOWN;
    endcase
  end

  // Lock FSM outputs: commas on every lane until UP, then the rotated word
  always_comb begin
    link_is_up = 1'b0;
    pipe_in    = {{NBYTES{1'b1}}, {NBYTES{COMMA}}};
    if (state_q == ST_UP) begin
      link_is_up = 1'b1;
      pipe_in    = {rot_k, rot_dat};
    end
  end

  serdes_delay_line #(
    .WIDTH (PW),
    .DEPTH (LATENCY)
  ) u_data_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pipe_in),
    .q_o   (pipe_out)
  );

  serdes_delay_line #(
    .WIDTH (1),
    .DEPTH (LATENCY)
  ) u_lock_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (link_is_up),
    .q_o   (rx_lock)
  );

  // Burst counter and saturating corrupted-word count
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q   <= '0;
      err_words_q <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      err_words_q <= err_words_d;
    end
  end

  // A trigger restarts the burst from err_len; otherwise count down one word per cycle
  always_comb begin
    err_cnt_d   = err_cnt_q;
    err_words_d = err_words_q;
    if (err_trig && (err_len != 8'd0)) begin
      err_cnt_d = err_len;
    end else if (err_cnt_q != 8'd0) begin
      err_cnt_d = err_cnt_q - 8'd1;
    end
    if ((err_cnt_q != 8'd0) && (err_words_q != 16'hFFFF)) begin
      err_words_d = err_words_q + 16'd1;
    end
  end

  assign err_busy  = (err_cnt_q != 8'd0);
  assign err_words = err_words_q;
  assign rx_k      = pipe_out[PW-1 -: NBYTES];
  assign rx_dat    = pipe_out[DW-1:0] ^ (err_busy ? err_mask : '0);

endmodule
